seven_segment_scan_decoder: RTL and testbench

Decodes a multiplexed, active-high 7-segment display bus back into per-digit BCD. It is the receive-side counterpart of the binary-to-7-segment encoder: it snoops the segment lines and one-hot digit selects of a scanned display, filters glitches, and assembles one multi-digit frame per scan. Completed frames go out over a valid/ready handshake to a logger or comparison checker.

---
 rtl/seven_segment_scan_decoder.sv | 151 +++++++++++++++
 tb/tb_seven_segment_scan_decoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_decoder.sv
// rtl/seven_segment_scan_decoder.sv - snoops a scanned 7-segment bus and rebuilds per-digit BCD frames
module seven_segment_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_i,
    input  logic [NUM_DIGITS-1:0]   dig_sel_i,
    input  logic                    frame_ready_i,
    output logic                    frame_valid_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic [NUM_DIGITS-1:0]   blank_o,
    output logic                    frame_err_o,
    output logic                    overrun_o
);

    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [7:0]            STABLE  = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    accept_q, accept_d;
    logic [4*NUM_DIGITS-1:0] nib_q, nib_d;
    logic [NUM_DIGITS-1:0]   blk_q, blk_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic                    perr_q, perr_d;
    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    ferr_q, ferr_d;
    logic                    ovr_q, ovr_d;

    logic                    changed;
    logic [3:0]              dec_nib;
    logic                    dec_blank, dec_bad;
    logic                    sel_onehot, capture, complete, load, err_new;
    logic [NUM_DIGITS-1:0]   mask_new;

    // Stability filter: counter restarts on any change of the sample registers.
    always_comb begin
        seg_d    = seg_i;
        sel_d    = dig_sel_i;
        changed  = (seg_i != seg_q) || (dig_sel_i != sel_q);
        cnt_d    = cnt_q;
        if (changed) begin
            cnt_d = 8'd1;
        end else if (cnt_q < STABLE) begin
            cnt_d = cnt_q + 8'd1;
        end
        accept_d = (cnt_d == STABLE) && (changed || (cnt_q != STABLE));
    end

    always_comb begin
        dec_nib   = 4'hE;
        dec_blank = 1'b0;
        dec_bad   = 1'b0;
        case (seg_q)
            7'h7E:   dec_nib = 4'd0;
            7'h30:   dec_nib = 4'd1;
            7'h6D:   dec_nib = 4'd2;
            7'h79:   dec_nib = 4'd3;
            7'h33:   dec_nib = 4'd4;
            7'h5B:   dec_nib = 4'd5;
            7'h5F:   dec_nib = 4'd6;
            7'h70:   dec_nib = 4'd7;
            7'h7F:   dec_nib = 4'd8;
            7'h7B:   dec_nib = 4'd9;
            7'h00: begin
                dec_nib   = 4'hF;
                dec_blank = 1'b1;
            end
            default: dec_bad = 1'b1;
        endcase
    end

    // Frame assembly; err_new is the error the completing frame carries before the flag clears.
    always_comb begin
        sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - SEL_ONE)) == '0);
        capture    = accept_q && sel_onehot;
        mask_new   = capture ? (mask_q | sel_q) : mask_q;
        err_new    = perr_q | (accept_q && (sel_q != '0) && !sel_onehot) | (capture && dec_bad);
        complete   = capture && (&mask_new);
        mask_d     = complete ? '0 : mask_new;
        perr_d     = complete ? 1'b0 : err_new;
        nib_d      = nib_q;
        blk_d      = blk_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (capture && sel_q[k]) begin
                nib_d[4*k +: 4] = dec_nib;
                blk_d[k]        = dec_blank;
            end
        end
    end

    always_comb begin
        load    = complete && ((state_q == EMPTY) || frame_ready_i);
        ovr_d   = complete && (state_q == FULL) && !frame_ready_i;
        bcd_d   = load ? nib_d : bcd_q;
        blank_d = load ? blk_d : blank_q;
        ferr_d  = load ? err_new : ferr_q;
        state_d = state_q;
        case (state_q)
            EMPTY:   if (complete) state_d = FULL;
            FULL:    if (frame_ready_i && !complete) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q    <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            accept_q <= 1'b0;
            nib_q    <= '0;
            blk_q    <= '0;
            mask_q   <= '0;
            perr_q   <= 1'b0;
            state_q  <= EMPTY;
            bcd_q    <= '0;
            blank_q  <= '0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            seg_q    <= seg_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
            nib_q    <= nib_d;
            blk_q    <= blk_d;
            mask_q   <= mask_d;
            perr_q   <= perr_d;
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            blank_q  <= blank_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign frame_valid_o = (state_q == FULL);
    assign bcd_o         = bcd_q;
    assign blank_o       = blank_q;
    assign frame_err_o   = ferr_q;
    assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// tb/tb_seven_segment_scan_decoder.sv - directed bench for seven_segment_scan_decoder
module tb_seven_segment_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_i;
    logic [3:0]  dig_sel_i;
    logic        frame_ready_i;
    logic        frame_valid_o;
    logic [15:0] bcd_o;
    logic [3:0]  blank_o;
    logic        frame_err_o;
    logic        overrun_o;

    int checks = 0;
    int errors = 0;

    seven_segment_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg_i(seg_i),
        .dig_sel_i(dig_sel_i),
        .frame_ready_i(frame_ready_i),
        .frame_valid_o(frame_valid_o),
        .bcd_o(bcd_o),
        .blank_o(blank_o),
        .frame_err_o(frame_err_o),
        .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic show(input logic [6:0] seg, input logic [3:0] sel, input int n);
        seg_i     = seg;
        dig_sel_i = sel;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        seg_i         = 7'h00;
        dig_sel_i     = 4'b0000;
        frame_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(frame_valid_o), 32'h0);
        chk("rst_bcd", 32'(bcd_o), 32'h0);
        chk("rst_blank", 32'(blank_o), 32'h0);
        chk("rst_err", 32'(frame_err_o), 32'h0);
        chk("rst_ovr", 32'(overrun_o), 32'h0);
        rst_n = 1'b1;
        show(7'h00, 4'b0000, 6);
        chk("idle_valid", 32'(frame_valid_o), 32'h0);

        // basic scan 4321
        show(7'h30, 4'b0001, 6);
        show(7'h6D, 4'b0010, 6);
        show(7'h79, 4'b0100, 6);
        show(7'h33, 4'b1000, 4);
        chk("lat_not_yet", 32'(frame_valid_o), 32'h0);
        @(posedge clk); #1;
        chk("lat_valid", 32'(frame_valid_o), 32'h1);
        chk("f1_bcd", 32'(bcd_o), 32'h4321);
        chk("f1_blank", 32'(blank_o), 32'h0);
        chk("f1_err", 32'(frame_err_o), 32'h0);
        @(posedge clk); #1;
        chk("f1_xfer", 32'(frame_valid_o), 32'h0);

        // glitch on digit 1 must be filtered
        show(7'h7E, 4'b0001, 6);
        show(7'h6D, 4'b0010, 2);
        show(7'h7F, 4'b0010, 2);
        show(7'h6D, 4'b0010, 6);
        show(7'h5B, 4'b0100, 6);
        show(7'h7F, 4'b1000, 6);
        chk("glitch_bcd", 32'(bcd_o), 32'h8520);
        chk("glitch_err", 32'(frame_err_o), 32'h0);

        // invalid pattern then a clean frame
        show(7'h30, 4'b0001, 6);
        show(7'h79, 4'b0010, 6);
        show(7'h41, 4'b0100, 6);
        show(7'h70, 4'b1000, 6);
        chk("bad_bcd", 32'(bcd_o), 32'h7E31);
        chk("bad_err", 32'(frame_err_o), 32'h1);
        show(7'h5F, 4'b0001, 6);
        show(7'h7B, 4'b0010, 6);
        show(7'h7E, 4'b0100, 6);
        show(7'h30, 4'b1000, 6);
        chk("clean_bcd", 32'(bcd_o), 32'h1096);
        chk("clean_err", 32'(frame_err_o), 32'h0);

        // blank digit
        show(7'h7E, 4'b0001, 6);
        show(7'h30, 4'b0010, 6);
        show(7'h6D, 4'b0100, 6);
        show(7'h00, 4'b1000, 6);
        chk("blank_bcd", 32'(bcd_o), 32'hF210);
        chk("blank_mask", 32'(blank_o), 32'h8);
        chk("blank_err", 32'(frame_err_o), 32'h0);

        // non-one-hot select: error, no capture
        frame_ready_i = 1'b0;
        show(7'h79, 4'b0011, 6);
        show(7'h5B, 4'b0010, 6);
        show(7'h5F, 4'b0100, 6);
        show(7'h70, 4'b1000, 6);
        chk("sel_nocap", 32'(frame_valid_o), 32'h0);
        show(7'h33, 4'b0001, 6);
        chk("sel_valid", 32'(frame_valid_o), 32'h1);
        chk("sel_bcd", 32'(bcd_o), 32'h7654);
        chk("sel_err", 32'(frame_err_o), 32'h1);

        // overrun while held
        show(7'h7E, 4'b0001, 6);
        show(7'h7E, 4'b0010, 6);
        show(7'h7E, 4'b0100, 6);
        show(7'h7E, 4'b1000, 5);
        chk("ovr_pulse", 32'(overrun_o), 32'h1);
        chk("ovr_valid", 32'(frame_valid_o), 32'h1);
        chk("ovr_held", 32'(bcd_o), 32'h7654);
        @(posedge clk); #1;
        chk("ovr_one", 32'(overrun_o), 32'h0);
        chk("ovr_held2", 32'(bcd_o), 32'h7654);

        // ready on the same edge as a completion
        show(7'h30, 4'b0001, 6);
        show(7'h30, 4'b0010, 6);
        show(7'h30, 4'b0100, 6);
        show(7'h30, 4'b1000, 4);
        chk("reload_pre", 32'(bcd_o), 32'h7654);
        frame_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("reload_valid", 32'(frame_valid_o), 32'h1);
        chk("reload_bcd", 32'(bcd_o), 32'h1111);
        chk("reload_ovr", 32'(overrun_o), 32'h0);
        chk("reload_err", 32'(frame_err_o), 32'h0);
        @(posedge clk); #1;
        chk("reload_xfer", 32'(frame_valid_o), 32'h0);

        // reset mid-frame
        show(7'h7E, 4'b0001, 6);
        show(7'h30, 4'b0010, 6);
        rst_n     = 1'b0;
        seg_i     = 7'h00;
        dig_sel_i = 4'b0000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_bcd", 32'(bcd_o), 32'h0);
        chk("mid_rst_valid", 32'(frame_valid_o), 32'h0);
        chk("mid_rst_err", 32'(frame_err_o), 32'h0);
        show(7'h6D, 4'b0100, 6);
        show(7'h79, 4'b1000, 6);
        chk("mid_rst_partial", 32'(frame_valid_o), 32'h0);
        chk("mid_rst_noload", 32'(bcd_o), 32'h0);
        show(7'h30, 4'b0001, 6);
        show(7'h5B, 4'b0010, 6);
        chk("mid_rst_bcd2", 32'(bcd_o), 32'h3251);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
